// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready pipeline that packs RV32I instruction fields into a 32-bit word.
// Ports: clk/rst (async active-high); in_valid/in_ready with fmt, op, funct3, funct7 (bit 30),
//        rd, rs1, rs2, imm field inputs; out_valid/out_ready with instr output; err (sticky);
//        count (instructions consumed, wraps).
// Optional: define INSTR_ENCODER_RANGE_CHECK_EN to flag out-of-range immediates on err.
module instr_encoder #(
    parameter int          COUNT_W  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [31:0]        imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instr,
    output logic               err,
    output logic [COUNT_W-1:0] count
);
    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_op;
    logic [2:0]  s1_funct3;
    logic        s1_funct7;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;
    logic        s2_load;
    logic        shift;
    logic        illegal;
    logic        range_err;
    logic [31:0] enc;

    assign s2_load  = !out_valid || out_ready;
    // rst gates in_ready so nothing is offered a handshake while reset is held
    assign in_ready = !rst && (!s1_valid || s2_load);

    always_comb begin
        shift   = s1_fmt == 3'b000 && s1_op == 7'b0010011 && s1_funct3[1:0] == 2'b01;
        illegal = s1_fmt[2:1] == 2'b11;
        case (s1_fmt)
            3'b000:  enc = shift ? {1'b0, s1_funct7, 5'b0, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_op}
                                 : {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_op};
            3'b001:  enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_op};
            3'b010:  enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:1], s1_imm[11], s1_op};
            3'b011:  enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
            3'b100:  enc = {s1_imm[31:12], s1_rd, s1_op};
            3'b101:  enc = {1'b0, s1_funct7, 5'b0, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_op};
            default: enc = NOP_WORD;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // a signed N-bit value has all bits from N-1 upward equal
    always_comb begin
        case (s1_fmt)
            3'b000:  range_err = shift ? |s1_imm[31:5] : !(&s1_imm[31:11] || ~|s1_imm[31:11]);
            3'b001:  range_err = !(&s1_imm[31:11] || ~|s1_imm[31:11]);
            3'b010:  range_err = !(&s1_imm[31:12] || ~|s1_imm[31:12]) || s1_imm[0];
            3'b011:  range_err = !(&s1_imm[31:20] || ~|s1_imm[31:20]) || s1_imm[0];
            3'b100:  range_err = |s1_imm[11:0];
            default: range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= '0;
            s1_op     <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= 1'b0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
            out_valid <= 1'b0;
            instr     <= '0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt    <= fmt;
                    s1_op     <= op;
                    s1_funct3 <= funct3;
                    s1_funct7 <= funct7;
                    s1_rd     <= rd;
                    s1_rs1    <= rs1;
                    s1_rs2    <= rs2;
                    s1_imm    <= imm;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    instr <= enc;
                    if (illegal || range_err)
                        err <= 1'b1;
                end
            end
            if (out_valid && out_ready)
                count <= count + COUNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-computed instruction words for instr_encoder.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7 = 1'b0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr;
    logic        err;
    logic [15:0] count;
    int          n_checks = 0;
    int          n_fails = 0;
    logic        exp_err = 1'b0;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        in_valid = 1'b1;
        fmt = f; op = o; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept, one edge to S2, check word, one more edge to consume it
    task automatic single(input string tag, input logic [31:0] exp, input logic [15:0] exp_cnt);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, instr, exp);
        tick();
        chk({tag, "_count"}, {16'd0, count}, {16'd0, exp_cnt});
    endtask

    initial begin
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        single("addi", 32'h0050_0093, 16'd1);
        put(3'b100, 7'b0110111, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        single("lui", 32'h1234_52B7, 16'd2);
        put(3'b011, 7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
        single("jal", 32'h0080_00EF, 16'd3);
        put(3'b000, 7'b0010011, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3);
        single("srai", 32'h4031_5093, 16'd4);

        put(3'b101, 7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        put(3'b001, 7'b0100011, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        in_valid = 1'b0;
        chk("sub", instr, 32'h4020_81B3);
        tick();
        chk("sw_b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("sw", instr, 32'h0020_A423);
        tick();
        chk("b2b_count", {16'd0, count}, 32'd6);

        put(3'b010, 7'b1100011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
        single("beq", 32'hFE00_0EE3, 16'd7);

        out_ready = 1'b0;
        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        tick();
        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        tick();
        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", instr, 32'h0010_0093);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_second", instr, 32'h0020_0113);
        tick();
        chk("bp_third", instr, 32'h0030_0193);
        tick();
        chk("bp_drain", {31'd0, out_valid}, 32'd0);
        chk("bp_count", {16'd0, count}, 32'd10);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        exp_err = 1'b1;
`endif
        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
        single("addi_2048", 32'h8000_0093, 16'd11);
        chk("range_err", {31'd0, err}, {31'd0, exp_err});

        put(3'b111, 7'b0110011, 3'd0, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("illegal_pre_err", {31'd0, err}, {31'd0, exp_err});
        tick();
        chk("illegal_nop", instr, 32'h0000_0013);
        chk("illegal_err", {31'd0, err}, 32'd1);
        tick();
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("illegal_count", {16'd0, count}, 32'd12);

        out_ready = 1'b0;
        put(3'b000, 7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
        tick();
        tick();
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_count", {16'd0, count}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        chk("post_rst_count", {16'd0, count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
